// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode constants, ula_op / alu_src encodings and the
// packed control bundle used by the decode and pipeline control logic.
// Optional feature macro: CTRL_MEXT_EN (widens ula_op to 3 bits for the
// M-extension encoding).
package ctrl_pkg;

`ifdef CTRL_MEXT_EN
    localparam int OP_W_CFG = 3;
`else
    localparam int OP_W_CFG = 2;
`endif

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [OP_W_CFG-1:0] ULA_ADD    = OP_W_CFG'(0);
    localparam logic [OP_W_CFG-1:0] ULA_BRANCH = OP_W_CFG'(1);
    localparam logic [OP_W_CFG-1:0] ULA_RTYPE  = OP_W_CFG'(2);
    localparam logic [OP_W_CFG-1:0] ULA_MEXT   = OP_W_CFG'(3);

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } src1_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'b00,
        SRC2_IMM  = 2'b01,
        SRC2_FOUR = 2'b10
    } src2_e;

    typedef struct packed {
        logic                branch;
        logic                jump;
        logic                jalr;
        logic [OP_W_CFG-1:0] ula_op;
        src1_e               alu_src1;
        src2_e               alu_src2;
        logic                mem_rd;
        logic                mem_wr;
        logic                reg_wr;
        logic                mux_reg_wr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Only R, S and B formats carry a real rs2 field; for everything else
    // those bits are immediate and must not trigger a load-use stall.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_R) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decode-side inputs and per-stage control outputs of the
// control pipeline. The pipeline uses the slave modport, the driver of the
// decode stage uses master. Optional feature macro: CTRL_MEXT_EN (sets the
// default ula_op width through ctrl_pkg).
interface ctrl_pipe_if
    import ctrl_pkg::*;
#(
    parameter int RD_W = 5,
    parameter int OP_W = OP_W_CFG
);
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [6:0]      id_funct7;
    logic [RD_W-1:0] id_rd;
    logic [RD_W-1:0] id_rs1;
    logic [RD_W-1:0] id_rs2;
    logic            ex_redirect;

    logic            ex_valid;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_jalr;
    logic [OP_W-1:0] ex_ula_op;
    logic [1:0]      ex_alu_src1;
    logic [1:0]      ex_alu_src2;
    logic [RD_W-1:0] ex_rd;

    logic            mem_valid;
    logic            mem_rd;
    logic            mem_wr;
    logic [RD_W-1:0] mem_rd_addr;

    logic            wb_valid;
    logic            wb_reg_wr;
    logic            wb_mux_reg_wr;
    logic [RD_W-1:0] wb_rd;

    logic            stall_out;
    logic            illegal_out;

    modport master (
        output id_valid, id_opcode, id_funct7, id_rd, id_rs1, id_rs2, ex_redirect,
        input  ex_valid, ex_branch, ex_jump, ex_jalr, ex_ula_op, ex_alu_src1,
               ex_alu_src2, ex_rd, mem_valid, mem_rd, mem_wr, mem_rd_addr,
               wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd, stall_out, illegal_out
    );

    modport slave (
        input  id_valid, id_opcode, id_funct7, id_rd, id_rs1, id_rs2, ex_redirect,
        output ex_valid, ex_branch, ex_jump, ex_jalr, ex_ula_op, ex_alu_src1,
               ex_alu_src2, ex_rd, mem_valid, mem_rd, mem_wr, mem_rd_addr,
               wb_valid, wb_reg_wr, wb_mux_reg_wr, wb_rd, stall_out, illegal_out
    );

endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> control bundle decode.
// Unknown opcodes produce an all-zero bundle plus an illegal flag.
// Optional feature macro: CTRL_MEXT_EN (R-type with funct7 0000001 selects
// the M-extension ula_op; without it funct7 is ignored).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RD_W = 5
) (
    input  logic [6:0]      i_opcode,
    input  logic [6:0]      i_funct7,
    input  logic [RD_W-1:0] i_rd,
    output ctrl_t           o_ctrl,
    output logic            o_illegal
);

    logic  w_is_mext;
    ctrl_t w_ctrl;

`ifdef CTRL_MEXT_EN
    assign w_is_mext = (i_funct7 == FUNCT7_MULDIV);
`else
    logic w_unused_funct7;
    assign w_is_mext       = 1'b0;
    assign w_unused_funct7 = ^i_funct7;
`endif

    // Table decode; U-type and jumps write their link/result into rd, and
    // any write aimed at x0 is dropped at the end.
    always_comb begin
        w_ctrl    = CTRL_NOP;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_R: begin
                w_ctrl.ula_op = w_is_mext ? ULA_MEXT : ULA_RTYPE;
                w_ctrl.reg_wr = 1'b1;
            end
            OPC_I_ALU: begin
                w_ctrl.ula_op   = ULA_RTYPE;
                w_ctrl.alu_src2 = SRC2_IMM;
                w_ctrl.reg_wr   = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl.mem_rd     = 1'b1;
                w_ctrl.alu_src2   = SRC2_IMM;
                w_ctrl.mux_reg_wr = 1'b1;
                w_ctrl.reg_wr     = 1'b1;
            end
            OPC_STORE: begin
                w_ctrl.mem_wr   = 1'b1;
                w_ctrl.alu_src2 = SRC2_IMM;
            end
            OPC_BRANCH: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.ula_op = ULA_BRANCH;
            end
            OPC_LUI: begin
                w_ctrl.alu_src1 = SRC1_ZERO;
                w_ctrl.alu_src2 = SRC2_IMM;
                w_ctrl.reg_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.alu_src1 = SRC1_PC;
                w_ctrl.alu_src2 = SRC2_IMM;
                w_ctrl.reg_wr   = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.jump     = 1'b1;
                w_ctrl.alu_src1 = SRC1_PC;
                w_ctrl.alu_src2 = SRC2_FOUR;
                w_ctrl.reg_wr   = 1'b1;
            end
            OPC_JALR: begin
                w_ctrl.jump     = 1'b1;
                w_ctrl.jalr     = 1'b1;
                w_ctrl.alu_src1 = SRC1_PC;
                w_ctrl.alu_src2 = SRC2_FOUR;
                w_ctrl.reg_wr   = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
        if (i_rd == '0) begin
            w_ctrl.reg_wr = 1'b0;
        end
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM and MEM/WB control registers with load-use stall
// detection and EX-resolved redirect squash. Decode is delegated to
// ctrl_decode; all state lives here. Optional feature macro: CTRL_MEXT_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int RD_W = 5,
    parameter int OP_W = OP_W_CFG
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_pipe_if.slave bus
);

    ctrl_t           w_id_ctrl;
    logic            w_id_illegal;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_stall;
    logic            w_id_accept;
    logic            w_id_flag_illegal;

    logic            r_ex_valid;
    ctrl_t           r_ex_ctrl;
    logic [RD_W-1:0] r_ex_rd;
    logic            r_ex_illegal;

    logic            r_mem_valid;
    logic            r_mem_rd_en;
    logic            r_mem_wr_en;
    logic            r_mem_reg_wr;
    logic            r_mem_mux_reg_wr;
    logic [RD_W-1:0] r_mem_rd_addr;

    logic            r_wb_valid;
    logic            r_wb_reg_wr;
    logic            r_wb_mux_reg_wr;
    logic [RD_W-1:0] r_wb_rd;

    ctrl_decode #(.RD_W(RD_W)) u_decode (
        .i_opcode  (bus.id_opcode),
        .i_funct7  (bus.id_funct7),
        .i_rd      (bus.id_rd),
        .o_ctrl    (w_id_ctrl),
        .o_illegal (w_id_illegal)
    );

    // A load in EX whose rd feeds the instruction in ID must stall one cycle;
    // a redirect wins because the ID instruction is being squashed anyway.
    assign w_rs1_hit = (bus.id_rs1 == r_ex_rd);
    assign w_rs2_hit = uses_rs2(bus.id_opcode) && (bus.id_rs2 == r_ex_rd);
    assign w_stall   = rst_n && !bus.ex_redirect && r_ex_valid && r_ex_ctrl.mem_rd
                       && (r_ex_rd != '0) && bus.id_valid && (w_rs1_hit || w_rs2_hit);

    assign w_id_accept       = bus.id_valid && !w_id_illegal && !w_stall && !bus.ex_redirect;
    assign w_id_flag_illegal = bus.id_valid && w_id_illegal && !w_stall && !bus.ex_redirect;

    // ID/EX: take the decoded instruction, or a bubble on stall/redirect/illegal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= CTRL_NOP;
            r_ex_rd      <= '0;
            r_ex_illegal <= 1'b0;
        end else begin
            r_ex_illegal <= w_id_flag_illegal;
            if (w_id_accept) begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= w_id_ctrl;
                r_ex_rd    <= bus.id_rd;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= CTRL_NOP;
                r_ex_rd    <= '0;
            end
        end
    end

    // EX/MEM: always advances, keeping only the controls later stages need.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_valid      <= 1'b0;
            r_mem_rd_en      <= 1'b0;
            r_mem_wr_en      <= 1'b0;
            r_mem_reg_wr     <= 1'b0;
            r_mem_mux_reg_wr <= 1'b0;
            r_mem_rd_addr    <= '0;
        end else begin
            r_mem_valid      <= r_ex_valid;
            r_mem_rd_en      <= r_ex_valid && r_ex_ctrl.mem_rd;
            r_mem_wr_en      <= r_ex_valid && r_ex_ctrl.mem_wr;
            r_mem_reg_wr     <= r_ex_valid && r_ex_ctrl.reg_wr;
            r_mem_mux_reg_wr <= r_ex_valid && r_ex_ctrl.mux_reg_wr;
            r_mem_rd_addr    <= r_ex_valid ? r_ex_rd : '0;
        end
    end

    // MEM/WB: always advances, carrying the register-file write controls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid      <= 1'b0;
            r_wb_reg_wr     <= 1'b0;
            r_wb_mux_reg_wr <= 1'b0;
            r_wb_rd         <= '0;
        end else begin
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_wr     <= r_mem_valid && r_mem_reg_wr;
            r_wb_mux_reg_wr <= r_mem_valid && r_mem_mux_reg_wr;
            r_wb_rd         <= r_mem_valid ? r_mem_rd_addr : '0;
        end
    end

    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_branch   = r_ex_valid && r_ex_ctrl.branch;
    assign bus.ex_jump     = r_ex_valid && r_ex_ctrl.jump;
    assign bus.ex_jalr     = r_ex_valid && r_ex_ctrl.jalr;
    assign bus.ex_ula_op   = r_ex_valid ? OP_W'(r_ex_ctrl.ula_op) : '0;
    assign bus.ex_alu_src1 = {2{r_ex_valid}} & r_ex_ctrl.alu_src1;
    assign bus.ex_alu_src2 = {2{r_ex_valid}} & r_ex_ctrl.alu_src2;
    assign bus.ex_rd       = r_ex_rd;

    assign bus.mem_valid   = r_mem_valid;
    assign bus.mem_rd      = r_mem_valid && r_mem_rd_en;
    assign bus.mem_wr      = r_mem_valid && r_mem_wr_en;
    assign bus.mem_rd_addr = r_mem_rd_addr;

    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_reg_wr     = r_wb_valid && r_wb_reg_wr;
    assign bus.wb_mux_reg_wr = r_wb_valid && r_wb_mux_reg_wr;
    assign bus.wb_rd         = r_wb_rd;

    assign bus.stall_out   = w_stall;
    assign bus.illegal_out = r_ex_illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe with an instruction-level
// reference model compared every cycle, plus hand-computed spot checks.
// Optional feature macro: CTRL_MEXT_EN (switches the expected ula_op width
// and the M-extension expectation).
module tb_ctrl_pipe;

`ifdef CTRL_MEXT_EN
    localparam int OP_W = 3;
    localparam int EXP_MUL_OP = 3;
`else
    localparam int OP_W = 2;
    localparam int EXP_MUL_OP = 2;
`endif
    localparam int RD_W = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        bit            v;
        bit            br;
        bit            jmp;
        bit            jalr;
        bit [OP_W-1:0] ula;
        bit [1:0]      s1;
        bit [1:0]      s2;
        bit            mrd;
        bit            mwr;
        bit            rw;
        bit            mux;
        bit [RD_W-1:0] rd;
        bit            ill;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     checks = 0;
    int     failures = 0;
    logic   lastStall;
    bit     modelReady = 1'b0;
    instr_t mEx, mMem, mWb;
    bit     mIll;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.RD_W(RD_W), .OP_W(OP_W)) bus ();

    ctrl_pipe #(.RD_W(RD_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic instr_t emptyInstr();
        instr_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Decode table of the instruction currently presented in ID.
    function automatic instr_t specDecode();
        instr_t d;
        d = emptyInstr();
        d.v  = 1'b1;
        d.rd = bus.id_rd;
        case (bus.id_opcode)
            OP_R: begin
                d.ula = OP_W'(2);
                d.rw  = 1'b1;
`ifdef CTRL_MEXT_EN
                if (bus.id_funct7 == 7'b0000001) d.ula = OP_W'(3);
`endif
            end
            OP_I:   begin d.ula = OP_W'(2); d.s2 = 2'b01; d.rw = 1'b1; end
            OP_LD:  begin d.mrd = 1'b1; d.s2 = 2'b01; d.mux = 1'b1; d.rw = 1'b1; end
            OP_S:   begin d.mwr = 1'b1; d.s2 = 2'b01; end
            OP_B:   begin d.br = 1'b1; d.ula = OP_W'(1); end
            OP_LUI: begin d.s1 = 2'b10; d.s2 = 2'b01; d.rw = 1'b1; end
            OP_AUI: begin d.s1 = 2'b01; d.s2 = 2'b01; d.rw = 1'b1; end
            OP_JAL: begin d.jmp = 1'b1; d.s1 = 2'b01; d.s2 = 2'b10; d.rw = 1'b1; end
            OP_JR:  begin d.jmp = 1'b1; d.jalr = 1'b1; d.s1 = 2'b01; d.s2 = 2'b10; d.rw = 1'b1; end
            default: begin d = emptyInstr(); d.ill = 1'b1; end
        endcase
        if (d.rd == 0) d.rw = 1'b0;
        return d;
    endfunction

    // Load-use hazard rule expressed on the model's EX instruction.
    function automatic bit expStall();
        bit useRs2;
        useRs2 = (bus.id_opcode == OP_R) || (bus.id_opcode == OP_S) || (bus.id_opcode == OP_B);
        return rst_n && !bus.ex_redirect && mEx.v && mEx.mrd && (mEx.rd != 0) && bus.id_valid
               && ((bus.id_rs1 == mEx.rd) || (useRs2 && (bus.id_rs2 == mEx.rd)));
    endfunction

    function automatic bit takeId();
        return bus.id_valid && !bus.ex_redirect && !expStall();
    endfunction

    function automatic instr_t modelNextEx();
        instr_t d;
        d = specDecode();
        return (takeId() && !d.ill) ? d : emptyInstr();
    endfunction

    function automatic bit modelNextIll();
        instr_t d;
        d = specDecode();
        return takeId() && d.ill;
    endfunction

    // Reference pipeline: each instruction moves one stage per clock.
    always @(posedge clk) begin
        if (!rst_n) begin
            mEx        <= emptyInstr();
            mMem       <= emptyInstr();
            mWb        <= emptyInstr();
            mIll       <= 1'b0;
            modelReady <= 1'b1;
        end else begin
            mWb  <= mMem;
            mMem <= mEx;
            mEx  <= modelNextEx();
            mIll <= modelNextIll();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every stage against the reference model.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("ex_stage",
                32'({bus.ex_valid, bus.ex_branch, bus.ex_jump, bus.ex_jalr, bus.ex_ula_op,
                     bus.ex_alu_src1, bus.ex_alu_src2, bus.ex_rd}),
                32'({mEx.v, mEx.br, mEx.jmp, mEx.jalr, mEx.ula, mEx.s1, mEx.s2, mEx.rd}));
            checkOutput("mem_stage",
                32'({bus.mem_valid, bus.mem_rd, bus.mem_wr, bus.mem_rd_addr}),
                32'({mMem.v, mMem.mrd, mMem.mwr, mMem.rd}));
            checkOutput("wb_stage",
                32'({bus.wb_valid, bus.wb_reg_wr, bus.wb_mux_reg_wr, bus.wb_rd}),
                32'({mWb.v, mWb.rw, mWb.mux, mWb.rd}));
            checkOutput("stall", 32'(bus.stall_out), 32'(expStall()));
            checkOutput("illegal", 32'(bus.illegal_out), 32'(mIll));
        end
    end

    // Present one decode-stage vector for one clock; stall is sampled mid-cycle.
    task automatic applyStimulus(input bit rstn, input bit v, input logic [6:0] opc,
                                 input logic [6:0] f7, input int rd, input int rs1,
                                 input int rs2, input bit redir);
        rst_n           = rstn;
        bus.id_valid    = v;
        bus.id_opcode   = opc;
        bus.id_funct7   = f7;
        bus.id_rd       = RD_W'(rd);
        bus.id_rs1      = RD_W'(rs1);
        bus.id_rs2      = RD_W'(rs2);
        bus.ex_redirect = redir;
        #2;
        lastStall = bus.stall_out;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 7'd0, 7'd0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_funct7 = '0;
        bus.id_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_redirect = 1'b0;

        // reset with a valid instruction in ID: nothing may enter
        applyStimulus(1'b0, 1'b1, OP_R, 7'd0, 3, 1, 2, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd0, 7'd0, 0, 0, 0, 1'b0);
        checkOutput("rst_ex_valid", 32'(bus.ex_valid), 32'(0));
        checkOutput("rst_mem_valid", 32'(bus.mem_valid), 32'(0));
        checkOutput("rst_wb_valid", 32'(bus.wb_valid), 32'(0));
        checkOutput("rst_illegal", 32'(bus.illegal_out), 32'(0));

        // add x3,x1,x2: EX after 1 cycle, WB after 3
        applyStimulus(1'b1, 1'b1, OP_R, 7'd0, 3, 1, 2, 1'b0);
        checkOutput("add_ex_valid", 32'(bus.ex_valid), 32'(1));
        checkOutput("add_ex_ula_op", 32'(bus.ex_ula_op), 32'(2));
        idle();
        idle();
        checkOutput("add_wb_reg_wr", 32'(bus.wb_reg_wr), 32'(1));
        checkOutput("add_wb_rd", 32'(bus.wb_rd), 32'(3));

        // lw x5 ; add x6,x5,x1 -> one stall cycle, add held in ID
        applyStimulus(1'b1, 1'b1, OP_LD, 7'd0, 5, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_R, 7'd0, 6, 5, 1, 1'b0);
        checkOutput("lu_stall", 32'(lastStall), 32'(1));
        checkOutput("lu_bubble", 32'(bus.ex_valid), 32'(0));
        checkOutput("lu_mem_rd", 32'(bus.mem_rd), 32'(1));
        applyStimulus(1'b1, 1'b1, OP_R, 7'd0, 6, 5, 1, 1'b0);
        checkOutput("lu_stall_release", 32'(lastStall), 32'(0));
        checkOutput("lu_add_ex_rd", 32'(bus.ex_rd), 32'(6));
        checkOutput("lu_wb_mux", 32'(bus.wb_mux_reg_wr), 32'(1));
        checkOutput("lu_wb_rd", 32'(bus.wb_rd), 32'(5));
        idle();

        // beq in EX redirects while addi x7 sits in ID
        applyStimulus(1'b1, 1'b1, OP_B, 7'd0, 0, 1, 2, 1'b0);
        checkOutput("beq_branch", 32'(bus.ex_branch), 32'(1));
        checkOutput("beq_ula_op", 32'(bus.ex_ula_op), 32'(1));
        applyStimulus(1'b1, 1'b1, OP_I, 7'd0, 7, 1, 0, 1'b1);
        checkOutput("redir_squash", 32'(bus.ex_valid), 32'(0));
        checkOutput("redir_beq_mem", 32'(bus.mem_valid), 32'(1));
        idle();
        checkOutput("redir_beq_wb_reg_wr", 32'(bus.wb_reg_wr), 32'(0));
        idle();
        checkOutput("redir_no_addi", 32'(bus.wb_valid), 32'(0));

        // illegal opcode, then addi x0
        applyStimulus(1'b1, 1'b1, OP_BAD, 7'd0, 4, 1, 2, 1'b0);
        checkOutput("ill_flag", 32'(bus.illegal_out), 32'(1));
        checkOutput("ill_ctrl_zero", 32'({bus.ex_valid, bus.ex_branch, bus.ex_jump, bus.ex_jalr,
                                          bus.ex_ula_op, bus.ex_alu_src1, bus.ex_alu_src2}), 32'(0));
        applyStimulus(1'b1, 1'b1, OP_I, 7'd0, 0, 1, 0, 1'b0);
        checkOutput("ill_flag_clear", 32'(bus.illegal_out), 32'(0));
        idle();
        idle();
        checkOutput("x0_wb_valid", 32'(bus.wb_valid), 32'(1));
        checkOutput("x0_no_write", 32'(bus.wb_reg_wr), 32'(0));

        // remaining formats
        applyStimulus(1'b1, 1'b1, OP_LUI, 7'd0, 9, 0, 0, 1'b0);
        checkOutput("lui_src", 32'({bus.ex_alu_src1, bus.ex_alu_src2}), 32'(4'b1001));
        applyStimulus(1'b1, 1'b1, OP_AUI, 7'd0, 10, 0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_JAL, 7'd0, 1, 0, 0, 1'b0);
        checkOutput("jal_jump_src2", 32'({bus.ex_jump, bus.ex_alu_src2}), 32'(3'b110));
        applyStimulus(1'b1, 1'b1, OP_JR, 7'd0, 1, 2, 0, 1'b0);
        checkOutput("jalr_flag", 32'(bus.ex_jalr), 32'(1));
        applyStimulus(1'b1, 1'b1, OP_S, 7'd0, 0, 2, 3, 1'b0);
        idle();
        checkOutput("sw_mem_wr", 32'(bus.mem_wr), 32'(1));

        // rs2 matters only for R/S/B
        applyStimulus(1'b1, 1'b1, OP_LD, 7'd0, 5, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_I, 7'd0, 6, 2, 5, 1'b0);
        checkOutput("rs2_ignored_itype", 32'(lastStall), 32'(0));
        applyStimulus(1'b1, 1'b1, OP_LD, 7'd0, 5, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_S, 7'd0, 0, 2, 5, 1'b0);
        checkOutput("rs2_store_stall", 32'(lastStall), 32'(1));
        applyStimulus(1'b1, 1'b1, OP_S, 7'd0, 0, 2, 5, 1'b0);
        idle();

        // redirect beats stall
        applyStimulus(1'b1, 1'b1, OP_LD, 7'd0, 5, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_R, 7'd0, 6, 5, 1, 1'b1);
        checkOutput("redir_over_stall", 32'(lastStall), 32'(0));
        idle();

        // reset with three instructions in flight and a hazard in ID
        applyStimulus(1'b1, 1'b1, OP_S, 7'd0, 0, 2, 3, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_I, 7'd0, 8, 1, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_LD, 7'd0, 11, 2, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_R, 7'd0, 12, 11, 1, 1'b0);
        checkOutput("rst_mid_stall_low", 32'(lastStall), 32'(0));
        checkOutput("rst_mid_valids", 32'({bus.ex_valid, bus.mem_valid, bus.wb_valid}), 32'(0));
        idle();
        checkOutput("rst_after_writes", 32'({bus.mem_wr, bus.wb_reg_wr}), 32'(0));
        idle();

        // funct7 handling for R-type
        applyStimulus(1'b1, 1'b1, OP_R, 7'b0000001, 13, 1, 2, 1'b0);
        checkOutput("mext_ula_op", 32'(bus.ex_ula_op), 32'(EXP_MUL_OP));
        applyStimulus(1'b1, 1'b1, OP_R, 7'b0000000, 14, 1, 2, 1'b0);
        checkOutput("rtype_ula_op", 32'(bus.ex_ula_op), 32'(2));
        idle();
        idle();
        idle();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter RD_W, default 5, meaning destination/source register address width.
REQ-002 SHALL have parameter OP_W, default 2, meaning ula_op width (forced to 3 when CTRL_MEXT_EN is defined).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports id_valid  input  1, id_opcode  input  7, id_funct7  input  7, id_rd/id_rs1/id_rs2  input  RD_W, carrying the instruction in decode.
REQ-006 SHALL have port ex_redirect  input  1  branch taken, jump or jalr resolved in EX; squashes younger instructions.
REQ-007 SHALL have ports ex_valid, ex_branch, ex_jump, ex_jalr (1 each), ex_ula_op (OP_W), ex_alu_src1, ex_alu_src2 (2 each), ex_rd (RD_W), all outputs of the ID/EX register.
REQ-008 SHALL have ports mem_valid, mem_rd, mem_wr (1 each), mem_rd_addr (RD_W), all outputs of the EX/MEM register.
REQ-009 SHALL have ports wb_valid, wb_reg_wr, wb_mux_reg_wr (1 each), wb_rd (RD_W), all outputs of the MEM/WB register.
REQ-010 SHALL have ports stall_out  output  1  hold PC and IF/ID, and illegal_out  output  1  registered illegal-opcode flag at EX.

Function
REQ-011 SHALL decode combinationally: R 0110011 -> ula_op 10, src1 00, src2 00, reg_wr; I-ALU 0010011 -> ula_op 10, src2 01, reg_wr; load 0000011 -> mem_rd, src2 01, mux_reg_wr 1, reg_wr; S 0100011 -> mem_wr, src2 01, no reg_wr; B 1100011 -> branch, ula_op 01, no reg_wr; LUI 0110111 -> src1 10, src2 01; AUIPC 0010111 -> src1 01, src2 01; JAL 1101111 -> jump, src1 01, src2 10; JALR 1100111 -> jump, jalr, src1 01, src2 10.
REQ-012 SHALL decode any other opcode as a bubble (all controls 0) and set illegal flag carried to EX.
REQ-013 SHALL force reg_wr to 0 when rd equals 0.
REQ-014 SHALL advance each stage register every cycle: ID->EX 1 cycle, EX->MEM 1 cycle, MEM->WB 1 cycle; total decode-to-WB latency 3 cycles.
REQ-015 SHALL assert stall_out when ex_valid and ex mem_rd and ex_rd != 0 and id_valid and (id_rs1 == ex_rd or id_rs2 == ex_rd); rs2 compare only for R, S, B opcodes.
REQ-016 SHALL, while stall_out, load a bubble (valid 0, all controls 0) into ID/EX and let EX/MEM, MEM/WB advance.
REQ-017 SHALL, on ex_redirect, load a bubble into ID/EX next cycle; the EX instruction itself advances to MEM normally.
REQ-018 SHALL give ex_redirect priority over stall: stall_out forced 0 when ex_redirect is 1.
REQ-019 SHALL drive all control outputs of a stage to 0 whenever that stage's valid is 0.

Reset
REQ-020 SHALL, on clk rising edge with rst_n low, clear all valid bits, controls, rd fields and illegal_out to 0.
REQ-021 SHALL, when rst_n is asserted mid-pipeline, discard every in-flight instruction; no write-enable asserts in the cycle after reset release.
REQ-022 SHALL hold stall_out at 0 while rst_n is low.

Configuration
REQ-023 SHALL, with CTRL_MEXT_EN defined, set OP_W to 3 and decode opcode 0110011 with id_funct7 0000001 as ula_op 011 (M-extension), else R decode as REQ-011.
REQ-024 SHALL, without CTRL_MEXT_EN, ignore id_funct7 entirely and keep OP_W at 2.

Structure
REQ-025 SHALL place opcode localparams, ula_op encodings, alu_src encodings and the packed control-bundle typedef in package ctrl_pkg.
REQ-026 SHALL instantiate one combinational sub-module ctrl_decode (opcode, funct7, rd -> control bundle, illegal); all state lives in ctrl_pipe.

Verification
REQ-027 SHALL test: add x3,x1,x2 (opcode 0110011, rd 3) at cycle 0 -> ex_ula_op 10 at cycle 1, wb_reg_wr 1, wb_rd 3 at cycle 3.
REQ-028 SHALL test: lw x5 then add x6,x5,x1 next cycle -> stall_out 1 for exactly one cycle, bubble in EX, add reaches EX one cycle late.
REQ-029 SHALL test: beq in EX with ex_redirect 1 while addi in ID -> ex_valid 0 next cycle, beq reaches mem_valid 1, no reg_wr from addi.
REQ-030 SHALL test: opcode 1111111 -> illegal_out 1 one cycle later, all controls 0; addi x0 -> wb_reg_wr 0.
REQ-031 SHALL test: rst_n low for one cycle with three valid instructions in flight -> all valids 0, no mem_wr or reg_wr asserted afterward.
REQ-032 SHALL test: with CTRL_MEXT_EN, opcode 0110011 funct7 0000001 -> ex_ula_op 011; funct7 0000000 -> 010.
